muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage of the pipelined CPU. It executes the multi-cycle multiply/divide class selected by the control unit's `multiDiv` field. It holds the pipeline via `stall` while it iterates, and returns a low result for the destination register and a high-half/remainder for R0. It replaces single-cycle ALU multiply/divide so that WIDTH can grow without lengthening the EX critical path.

## Interface
- `WIDTH`, 16: operand/result width; even, ≥4.
- `clk` input 1: clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level request; op valid in EX.
- `op` input 1: 0 = multiply, 1 = divide.
- `op_signed` input 1: signed operation. Present in both builds; see Configuration.
- `a` input WIDTH: multiplicand / dividend.
- `b` input WIDTH: multiplier / divisor.
- `flush` input 1: synchronous abort.
- `busy` output 1: state == RUN.
- `stall` output 1: combinational `(state==RUN) | (state==IDLE & start & ~flush)`; holds IF/ID/EX buffers.
- `done` output 1: one-cycle result-valid pulse (state == DONE).
- `result` output WIDTH: product low half / quotient.
- `overflow` output WIDTH: product high half / remainder. Written to R0.
- `div_by_zero` output 1: set with `done` when divide had b == 0.

## Operation
- States: IDLE, RUN, DONE. A WIDTH-counting iteration counter is held in a `$clog2(WIDTH)+1`-bit register.
- IDLE: on an edge with `start & ~flush`, latch operands and `op`/`op_signed`.
  - Divide with b == 0: go to DONE directly. Load `result` = all ones, `overflow` = a, `div_by_zero` = 1.
  - Otherwise: go to RUN with counter = WIDTH, `div_by_zero` = 0.
- RUN: one radix-2 step per edge, counter decrements. On the edge where counter == 1, the final step executes, the outputs are registered, and the state moves to DONE.
  - Multiply: shift-add over a 2·WIDTH accumulator. `{overflow,result}` = a·b, exact; no truncation.
  - Divide: restoring, one quotient bit per step. `result` = ⌊a/b⌋, `overflow` = a mod b.
- DONE: `done` = 1 for exactly one cycle; `stall` = 0 so the instruction leaves EX. Next edge goes to IDLE unconditionally; `start` is ignored in DONE.
  - This rule prevents a still-asserted `start` from re-launching the same instruction.
- `result`, `overflow` and `div_by_zero` hold their values from DONE until the next accepted start.
- `flush` in any state: next edge goes to IDLE. Outputs are unchanged, `done` is never asserted for the aborted op, and the counter clears. `flush` wins over `start` on the same edge.
- Internal accumulators are not observable; only the registered outputs change at DONE entry.

## Timing
- Reset (async assert, sync release by system): state IDLE, counter 0. `busy`, `done`, `div_by_zero` = 0; `result`, `overflow` = 0. Reset mid-RUN discards the op.
- Latency, start-accepting edge E:
  - Normal op: `done` is high in the cycle after edge E+WIDTH (WIDTH cycles in RUN).
  - Divide by zero: `done` is high in the cycle after edge E.
- Back-to-back ops: DONE → IDLE → accept. Minimum issue interval is WIDTH+2 cycles.
- `stall` is combinational from `start`/`flush`/state. No other output is combinational.

## Configuration
- `MULDIV_SIGNED_EN` defined: `op_signed` is honoured.
  - Operands are converted to magnitudes and the step engine runs unsigned.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Signed divide of most-negative ÷ −1: `result` = most-negative, `overflow` = 0, `div_by_zero` = 0, normal latency.
  - Signed divide by zero: `result` = all ones, `overflow` = a.
- Undefined: `op_signed` is ignored and all ops are unsigned. The port remains for pin compatibility; the sign-fixup logic is absent.

## Test plan
- Unsigned multiply (WIDTH=16): mul 0x1234 × 0x0100 → `result` 0x3400, `overflow` 0x0012, `done` in the cycle after edge E+16, `stall` high for exactly 17 cycles counted from the IDLE request cycle.
- Unsigned multiply, largest operands: mul 0xFFFF × 0xFFFF unsigned → `result` 0x0001, `overflow` 0xFFFE.
- Unsigned divide: div 100 ÷ 7 → `result` 14, `overflow` 2, `div_by_zero` 0. Hold `start` high through DONE → no relaunch, state IDLE next cycle.
- Divide by zero: div 0x0055 ÷ 0 → `result` 0xFFFF, `overflow` 0x0055, `div_by_zero` 1, `done` in the cycle after edge E.
- Abort: flush at RUN cycle 5 → IDLE next edge, no `done`, outputs keep prior values. Separately, reset_n low mid-RUN → all outputs 0 immediately.
- Signed (`MULDIV_SIGNED_EN`): −7 ÷ 2 → `result` 0xFFFD, `overflow` 0xFFFF; 0x8000 ÷ 0xFFFF → 0x8000 rem 0; −3 × 5 → `{overflow,result}` 0xFFFF_FFF1.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 multiply / restoring divide for the EX stage.
//            Define MULDIV_SIGNED_EN to honour op_signed (sign-magnitude fixup).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] overflow,
    output logic             div_by_zero
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_m;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_res_fin;
    logic [WIDTH-1:0]   w_ovf_fin;

    // Multiply: r_lo holds the multiplier, r_m the multiplicand, r_hi the
    // upper accumulator. Divide: r_lo holds dividend bits shifting into the
    // quotient, r_hi the partial remainder, r_m the divisor.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mhi;
    logic [WIDTH-1:0]   w_mlo;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_dhi;
    logic [WIDTH-1:0]   w_dlo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;

    assign w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_m}) : {1'b0, r_hi};
    assign w_mhi   = w_sum[WIDTH:1];
    assign w_mlo   = {w_sum[0], r_lo[WIDTH-1:1]};

    // Remainder stays below the divisor, so the subtraction fits in WIDTH bits
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    assign w_diff  = w_shift[WIDTH-1:0] - r_m;
    assign w_dhi   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_dlo   = {r_lo[WIDTH-2:0], w_ge};

    assign w_hi_nxt = r_op ? w_dhi : w_mhi;
    assign w_lo_nxt = r_op ? w_dlo : w_mlo;

`ifdef MULDIV_SIGNED_EN
    logic               w_a_neg;
    logic               w_b_neg;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = op_signed & a[WIDTH-1];
    assign w_b_neg = op_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;

    always_comb begin
        w_prod    = {w_hi_nxt, w_lo_nxt};
        w_res_fin = w_lo_nxt;
        w_ovf_fin = w_hi_nxt;
        if (r_op) begin
            if (r_neg_q) w_res_fin = ~w_lo_nxt + WIDTH'(1);
            if (r_neg_r) w_ovf_fin = ~w_hi_nxt + WIDTH'(1);
        end else if (r_neg_q) begin
            w_prod    = ~{w_hi_nxt, w_lo_nxt} + (2*WIDTH)'(1);
            w_res_fin = w_prod[WIDTH-1:0];
            w_ovf_fin = w_prod[2*WIDTH-1:WIDTH];
        end
    end
`else
    logic w_unused_op_signed;

    assign w_unused_op_signed = op_signed;
    assign w_a_mag   = a;
    assign w_b_mag   = b;
    assign w_res_fin = w_lo_nxt;
    assign w_ovf_fin = w_hi_nxt;
`endif

    assign stall = (r_state == S_RUN) | ((r_state == S_IDLE) & start & ~flush);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            overflow    <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_hi <= '0;
                        r_lo <= op ? w_a_mag : w_b_mag;
                        r_m  <= op ? w_b_mag : w_a_mag;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
`endif
                        if (op && (b == '0)) begin
                            result      <= '1;
                            overflow    <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            r_cnt       <= c_cnt_w'(WIDTH);
                            busy        <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        result   <= w_res_fin;
                        overflow <= w_ovf_fin;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A still-high start must not relaunch the retiring op
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed-vector bench with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 16;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         op_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] overflow;
    logic         div_by_zero;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .op_signed(op_signed),
        .a(a), .b(b), .flush(flush), .busy(busy), .stall(stall), .done(done),
        .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: visible output values and expected timing window
    bit           chk_en   = 1'b0;
    int           done_cyc = -1;
    int           busy_lo  = 0;
    int           busy_hi  = -1;
    logic [W-1:0] vis_res  = '0;
    logic [W-1:0] vis_ovf  = '0;
    logic         vis_dbz  = 1'b0;
    logic [W-1:0] pend_res;
    logic [W-1:0] pend_ovf;
    logic         pend_dbz;

    function automatic void model_calc(input bit o, input bit s, input logic [W-1:0] x,
                                       input logic [W-1:0] y, output logic [W-1:0] r,
                                       output logic [W-1:0] ov, output logic z);
        longint sx, sy, p, q, m;
        bit     sg;
        sg = s & SIGNED_BUILD;
        sx = sg ? longint'($signed(x)) : longint'(x);
        sy = sg ? longint'($signed(y)) : longint'(y);
        z  = 1'b0;
        if (!o) begin
            p  = sx * sy;
            r  = p[15:0];
            ov = p[31:16];
        end else if (y == '0) begin
            r  = '1;
            ov = x;
            z  = 1'b1;
        end else begin
            q  = sx / sy;
            m  = sx % sy;
            r  = q[15:0];
            ov = m[15:0];
        end
    endfunction

    task automatic launch(input bit o, input bit s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int e);
        model_calc(o, s, x, y, pend_res, pend_ovf, pend_dbz);
        busy_lo = e;
        if (pend_dbz) begin
            done_cyc = e;
            busy_hi  = e - 1;
        end else begin
            done_cyc = e + W;
            busy_hi  = e + W - 1;
            vis_dbz  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == done_cyc) begin
                vis_res = pend_res;
                vis_ovf = pend_ovf;
                vis_dbz = pend_dbz;
            end
            chk("done", done, (cyc == done_cyc));
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            chk("result", result, vis_res);
            chk("overflow", overflow, vis_ovf);
            chk("div_by_zero", div_by_zero, vis_dbz);
        end
    end

    task automatic run_op(input string nm, input bit o, input bit s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic [W-1:0] eo,
                          input bit ez, input int elat, input int estall, input bit hold);
        int e, sc, dc;
        bit seen;
        @(negedge clk); #2;
        op = o; op_signed = s; a = x; b = y; start = 1'b1;
        #1 sc = stall ? 1 : 0;
        @(posedge clk); #1;
        e = cyc;
        launch(o, s, x, y, e);
        if (!hold) start = 1'b0;
        seen = 1'b0;
        dc   = -1;
        for (int k = 0; k < W + 4 && !seen; k++) begin
            @(negedge clk); #2;
            if (done) begin
                seen = 1'b1;
                dc   = cyc;
            end else if (stall) begin
                sc++;
            end
        end
        chk({nm, " done_seen"}, seen, 1);
        if (seen) begin
            chk({nm, " latency"}, dc - e, elat);
            chk({nm, " stall_cycles"}, sc, estall);
            chk({nm, " stall_in_done"}, stall, 0);
            chk({nm, " result"}, result, er);
            chk({nm, " overflow"}, overflow, eo);
            chk({nm, " div_by_zero"}, div_by_zero, ez);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 16'h0000);
        chk("reset overflow", overflow, 16'h0000);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", div_by_zero, 0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run_op("mul_basic", 1'b0, 1'b0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, W, W + 1, 1'b0);
        run_op("mul_max",   1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, W, W + 1, 1'b0);
        run_op("div_hold",  1'b1, 1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, W, W + 1, 1'b1);
        run_op("div_zero",  1'b1, 1'b0, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 1'b1, 0, 1, 1'b0);
        run_op("mul_zero",  1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, W, W + 1, 1'b0);
        run_op("div_small", 1'b1, 1'b0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0, W, W + 1, 1'b0);
        run_op("div_one",   1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, W, W + 1, 1'b0);
`ifdef MULDIV_SIGNED_EN
        run_op("sdiv_neg7", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, W, W + 1, 1'b0);
        run_op("sdiv_min",  1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, W, W + 1, 1'b0);
        run_op("smul_neg3", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, W, W + 1, 1'b0);
`else
        run_op("sdiv_neg7", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, W, W + 1, 1'b0);
        run_op("sdiv_min",  1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, W, W + 1, 1'b0);
        run_op("smul_neg3", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 1'b0, W, W + 1, 1'b0);
`endif
        run_op("sdiv_zero", 1'b1, 1'b1, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1'b1, 0, 1, 1'b0);

        // Abort during the fifth RUN cycle
        @(negedge clk); #2;
        op = 1'b0; op_signed = 1'b0; a = 16'd3; b = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        launch(1'b0, 1'b0, 16'd3, 16'd4, e);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        flush    = 1'b1;
        done_cyc = -1;
        busy_hi  = cyc;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (W + 3) @(negedge clk);
        #2;
        chk("flush held result", result, 16'hFFFF);
        chk("flush held overflow", overflow, 16'h8001);
        chk("flush busy", busy, 0);

        // Flush beats start in IDLE
        @(negedge clk); #2;
        op = 1'b0; a = 16'd2; b = 16'd2; start = 1'b1; flush = 1'b1;
        #1 chk("flush_vs_start stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of RUN
        @(negedge clk); #2;
        op = 1'b0; a = 16'h1234; b = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        launch(1'b0, 1'b0, 16'h1234, 16'h0100, e);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun reset result", result, 16'h0000);
        chk("midrun reset overflow", overflow, 16'h0000);
        chk("midrun reset busy", busy, 0);
        chk("midrun reset done", done, 0);
        chk("midrun reset dbz", div_by_zero, 0);
        vis_res  = '0;
        vis_ovf  = '0;
        vis_dbz  = 1'b0;
        done_cyc = -1;
        busy_hi  = -1;
        @(negedge clk); #2;
        reset_n = 1'b1;
        repeat (W + 2) @(negedge clk);

        run_op("mul_after_reset", 1'b0, 1'b0, 16'd7, 16'd6, 16'h002A, 16'h0000, 1'b0, W, W + 1, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
